// File: rtl/pong_pkg.sv
// Shared definitions for the vPong game sequencer: match FSM encoding and default sizes.
package pong_pkg;
  localparam int SCORE_W_DEF   = 4;
  localparam int WIN_SCORE_DEF = 9;
  localparam int FCNT_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;
endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector; evt_o rises 3 cycles after the pin.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);
  logic meta_q, sync_q, prev_q, evt_q;
  logic meta_d, sync_d, prev_d, evt_d;

  always_comb begin
    meta_d = btn_i;
    sync_d = meta_q;
    prev_d = sync_q;
    evt_d  = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt_o = evt_q;
endmodule

// File: rtl/pong_game_sequencer.sv
// vPong match controller: FSM, scores, per-frame move tick and ball restart pulse.
// Optional SPEED_RAMP_EN: each paddle hit shortens the tick period down to DIV_MIN.
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int DIV_INIT     = 12,
  parameter int DIV_MIN      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               frame_pulse,
  input  logic               start_btn,
  input  logic               goal1,
  input  logic               goal2,
  input  logic               paddle_hit,
  output logic               move_tick,
  output logic               ball_restart,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [2:0]         state
);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);

  state_e               state_q, state_d;
  logic [FCNT_W-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic                 dir_q, dir_d, tick_q, tick_d, rst_q, rst_d;
  logic                 start_evt;
  logic [FCNT_W-1:0]    period;

  btn_sync_edge u_start (
    .clk   (Clk),
    .rst_n (reset),
    .btn_i (start_btn),
    .evt_o (start_evt)
  );

`ifdef SPEED_RAMP_EN
  // div_q follows paddle hits; per_q is the period in force, latched at each tick.
  logic [FCNT_W-1:0] div_q, div_d, per_q, per_d;
  assign period = per_q;
`else
  logic unused_cfg;
  assign period     = FCNT_W'(DIV_INIT);
  assign unused_cfg = ^{paddle_hit, FCNT_W'(DIV_MIN)};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    rst_d   = 1'b0;
`ifdef SPEED_RAMP_EN
    div_d   = div_q;
    per_d   = per_q;
`endif
    case (state_q)
      S_IDLE: if (start_evt) begin
        state_d = S_SERVE;
        cnt_d   = '0;
        rst_d   = 1'b1;
      end
      S_SERVE: if (frame_pulse) begin
        if (cnt_q == SERVE_LAST) begin
          state_d = S_PLAY;
          cnt_d   = '0;
`ifdef SPEED_RAMP_EN
          div_d   = FCNT_W'(DIV_INIT);
          per_d   = FCNT_W'(DIV_INIT);
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      S_PLAY: begin
        // goal1 has priority; a goal cycle suppresses any tick on the same frame
        if (goal1) begin
          if (s1_q < WIN) s1_d = s1_q + 1'b1;
          dir_d   = 1'b1;
          state_d = S_POINT;
          cnt_d   = '0;
        end else if (goal2) begin
          if (s2_q < WIN) s2_d = s2_q + 1'b1;
          dir_d   = 1'b0;
          state_d = S_POINT;
          cnt_d   = '0;
        end else begin
`ifdef SPEED_RAMP_EN
          if (paddle_hit && div_q > FCNT_W'(DIV_MIN)) div_d = div_q - 1'b1;
`endif
          if (frame_pulse) begin
            if (cnt_q == period - 1'b1) begin
              tick_d = 1'b1;
              cnt_d  = '0;
`ifdef SPEED_RAMP_EN
              per_d  = div_d;
`endif
            end else cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_POINT: if (frame_pulse) begin
        if (cnt_q == POINT_LAST) begin
          cnt_d = '0;
          if (s1_q == WIN || s2_q == WIN) state_d = S_OVER;
          else begin
            state_d = S_SERVE;
            rst_d   = 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      S_OVER: if (start_evt) begin
        s1_d    = '0;
        s2_d    = '0;
        dir_d   = 1'b0;
        state_d = S_SERVE;
        cnt_d   = '0;
        rst_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      rst_q   <= 1'b0;
`ifdef SPEED_RAMP_EN
      div_q   <= FCNT_W'(DIV_INIT);
      per_q   <= FCNT_W'(DIV_INIT);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      rst_q   <= rst_d;
`ifdef SPEED_RAMP_EN
      div_q   <= div_d;
      per_q   <= per_d;
`endif
    end
  end

  assign move_tick    = tick_q;
  assign ball_restart = rst_q;
  assign serve_dir    = dir_q;
  assign score1       = s1_q;
  assign score2       = s2_q;
  assign game_over    = (state_q == S_OVER);
  assign state        = state_q;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed step table, async reset check, random run vs reference model.
module tb_pong_game_sequencer;
  logic Clk = 1'b0, reset = 1'b0;
  logic frame_pulse = 1'b0, start_btn = 1'b0, goal1 = 1'b0, goal2 = 1'b0, paddle_hit = 1'b0;
  logic move_tick, ball_restart, serve_dir, game_over;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int checks = 0, errors = 0;
  int tick_seen = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  pong_game_sequencer dut (
    .Clk(Clk), .reset(reset), .frame_pulse(frame_pulse), .start_btn(start_btn),
    .goal1(goal1), .goal2(goal2), .paddle_hit(paddle_hit),
    .move_tick(move_tick), .ball_restart(ball_restart), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over), .state(state)
  );

  // Reference model: match phase plus "frames seen in this phase", counted up to the target.
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;
  int m_mode = IDLE, m_frames = 0, m_s1 = 0, m_s2 = 0, m_div = 12, m_per = 12;
  bit m_dir = 0, m_tick = 0, m_rst = 0;
  bit hist[4] = '{0, 0, 0, 0};

  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_mode = IDLE; m_frames = 0; m_s1 = 0; m_s2 = 0; m_div = 12; m_per = 12;
      m_dir = 0; m_tick = 0; m_rst = 0; hist = '{0, 0, 0, 0};
    end else begin : step
      bit evt;
      evt = hist[2] & ~hist[3];
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = start_btn;
      m_tick = 0; m_rst = 0;
      case (m_mode)
        IDLE: if (evt) begin m_mode = SERVE; m_frames = 0; m_rst = 1; end
        SERVE: if (frame_pulse) begin
          m_frames++;
          if (m_frames == 60) begin m_mode = PLAY; m_frames = 0; m_div = 12; m_per = 12; end
        end
        PLAY: begin
          if (goal1) begin
            m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1; m_dir = 1; m_mode = POINT; m_frames = 0;
          end else if (goal2) begin
            m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1; m_dir = 0; m_mode = POINT; m_frames = 0;
          end else begin
`ifdef SPEED_RAMP_EN
            if (paddle_hit) m_div = (m_div - 1 < 4) ? 4 : m_div - 1;
`endif
            if (frame_pulse) begin
              m_frames++;
              if (m_frames == m_per) begin m_tick = 1; m_frames = 0; m_per = m_div; end
            end
          end
        end
        POINT: if (frame_pulse) begin
          m_frames++;
          if (m_frames == 90) begin
            m_frames = 0;
            if (m_s1 == 9 || m_s2 == 9) m_mode = OVER;
            else begin m_mode = SERVE; m_rst = 1; end
          end
        end
        default: if (evt) begin
          m_s1 = 0; m_s2 = 0; m_dir = 0; m_mode = SERVE; m_frames = 0; m_rst = 1;
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (move_tick === 1'b1) tick_seen++;
    if (chk_en) begin
      checks++;
      if (state !== 3'(m_mode) || score1 !== 4'(m_s1) || score2 !== 4'(m_s2) ||
          serve_dir !== m_dir || move_tick !== m_tick || ball_restart !== m_rst ||
          game_over !== (m_mode == OVER)) begin
        errors++;
        if (errors <= 10)
          $display("FAIL cycle t=%0t got st=%0d s1=%0d s2=%0d dir=%b tick=%b rst=%b over=%b expected st=%0d s1=%0d s2=%0d dir=%b tick=%b rst=%b over=%b",
                   $time, state, score1, score2, serve_dir, move_tick, ball_restart, game_over,
                   m_mode, m_s1, m_s2, m_dir, m_tick, m_rst, m_mode == OVER);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n); repeat (n) @(negedge Clk); endtask
  task automatic frames(int n);
    repeat (n) begin
      @(negedge Clk); frame_pulse = 1'b1;
      @(negedge Clk); frame_pulse = 1'b0;
      cyc(2);
    end
  endtask
  task automatic press_start();
    @(negedge Clk); start_btn = 1'b1; cyc(2); start_btn = 1'b0; cyc(5);
  endtask
  task automatic goal(logic g1, logic g2);
    @(negedge Clk); goal1 = g1; goal2 = g2;
    @(negedge Clk); goal1 = 1'b0; goal2 = 1'b0; cyc(2);
  endtask
  task automatic hits(int n);
    repeat (n) begin @(negedge Clk); paddle_hit = 1'b1; @(negedge Clk); paddle_hit = 1'b0; end
    cyc(2);
  endtask

  localparam int OP_START = 0, OP_FR = 1, OP_G1 = 2, OP_G2 = 3, OP_BOTH = 4, OP_HIT = 5;
  typedef struct { int op; int n; int st; int s1; int s2; int dir; int ticks; } vec_t;
  vec_t tbl[$];

  function automatic void add(int op, int n, int st, int s1, int s2, int dir, int ticks);
    vec_t v;
    v.op = op; v.n = n; v.st = st; v.s1 = s1; v.s2 = s2; v.dir = dir; v.ticks = ticks;
    tbl.push_back(v);
  endfunction

  initial begin
`ifdef SPEED_RAMP_EN
    int ramp_ticks = 2;
`else
    int ramp_ticks = 0;
`endif
    add(OP_START, 0, 1, 0, 0, 0, -1);
    add(OP_FR, 59, 1, 0, 0, 0, 0);
    add(OP_FR, 1, 2, 0, 0, 0, 0);
    add(OP_FR, 11, 2, 0, 0, 0, 0);
    add(OP_FR, 1, 2, 0, 0, 0, 1);
    add(OP_FR, 24, 2, 0, 0, 0, 2);
    add(OP_HIT, 10, 2, 0, 0, 0, 0);
    add(OP_FR, 12, 2, 0, 0, 0, 1);
    add(OP_FR, 8, 2, 0, 0, 0, ramp_ticks);
    add(OP_BOTH, 0, 3, 1, 0, 1, 0);
    add(OP_FR, 89, 3, 1, 0, 1, 0);
    add(OP_FR, 1, 1, 1, 0, 1, 0);
    add(OP_FR, 60, 2, 1, 0, 1, 0);
    add(OP_FR, 11, 2, 1, 0, 1, 0);
    add(OP_FR, 1, 2, 1, 0, 1, 1);
    add(OP_G2, 0, 3, 1, 1, 0, 0);
    add(OP_FR, 90, 1, 1, 1, 0, 0);
    for (int k = 2; k <= 8; k++) begin
      add(OP_FR, 60, 2, 1, k - 1, 0, 0);
      add(OP_G2, 0, 3, 1, k, 0, 0);
      add(OP_FR, 90, 1, 1, k, 0, 0);
    end
    add(OP_FR, 60, 2, 1, 8, 0, 0);
    add(OP_G2, 0, 3, 1, 9, 0, 0);
    add(OP_FR, 89, 3, 1, 9, 0, 0);
    add(OP_FR, 1, 4, 1, 9, 0, 0);
    add(OP_G1, 0, 4, 1, 9, 0, 0);
    add(OP_FR, 5, 4, 1, 9, 0, 0);
    add(OP_START, 0, 1, 0, 0, 0, -1);
    for (int k = 1; k <= 3; k++) begin
      add(OP_FR, 60, 2, k - 1, 0, (k == 1) ? 0 : 1, 0);
      add(OP_G1, 0, 3, k, 0, 1, 0);
      add(OP_FR, 90, 1, k, 0, 1, 0);
    end
    add(OP_FR, 60, 2, 3, 0, 1, 0);

    cyc(3);
    chk("reset_state", 32'(state), 0);
    chk("reset_outs", 32'({move_tick, ball_restart, serve_dir, game_over, score1, score2}), 0);
    @(negedge Clk); reset = 1'b1;
    chk_en = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick_seen = 0;
      case (tbl[i].op)
        OP_START: press_start();
        OP_FR:    frames(tbl[i].n);
        OP_G1:    goal(1'b1, 1'b0);
        OP_G2:    goal(1'b0, 1'b1);
        OP_BOTH:  goal(1'b1, 1'b1);
        default:  hits(tbl[i].n);
      endcase
      chk($sformatf("step%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("step%0d_scores", i), 32'({score1, score2}), 32'({4'(tbl[i].s1), 4'(tbl[i].s2)}));
      chk($sformatf("step%0d_dir_over", i), 32'({serve_dir, game_over}),
          32'({1'(tbl[i].dir), 1'(tbl[i].st == 4)}));
      if (tbl[i].ticks >= 0) chk($sformatf("step%0d_ticks", i), 32'(tick_seen), 32'(tbl[i].ticks));
    end

    // asynchronous reset in the middle of play with score1=3
    @(negedge Clk); #2 reset = 1'b0; #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_score1", 32'(score1), 0);
    chk("async_rst_outs", 32'({move_tick, ball_restart, serve_dir, game_over, score2}), 0);
    @(negedge Clk); reset = 1'b1;

    for (int c = 0; c < 20000; c++) begin
      @(negedge Clk);
      frame_pulse = ($urandom_range(0, 2) == 0);
      goal1       = ($urandom_range(0, 149) == 0);
      goal2       = ($urandom_range(0, 149) == 0);
      paddle_hit  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) start_btn = ~start_btn;
    end
    @(negedge Clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
